// File: rtl/db9_md_pad_scan.sv
// Two-port DB9 pad scanner: walks the MD select sequence on each port in turn and
// decodes Atari 2-button, MD 3-button and MD 6-button pads into active-high words.
module db9_md_pad_scan #(
    parameter int STEP_CYC = 256,
    parameter int IDLE_CYC = 49152
) (
    input  logic        I_CLK,
    input  logic        I_RESETn,
    input  logic [5:0]  I_JOY_IN,
    output logic        O_SPLIT,
    output logic        O_MDSEL,
    output logic [15:0] O_JOY1,
    output logic [15:0] O_JOY2,
    output logic [1:0]  O_TYPE1,
    output logic [1:0]  O_TYPE2,
    output logic        O_STB1,
    output logic        O_STB2
);
    localparam int CNT_MAX = (IDLE_CYC > STEP_CYC) ? IDLE_CYC : STEP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_SCAN   = 2'd1,
        ST_IDLE   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         phase_reg, phase_next;
    logic               port_reg, port_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               mdsel_reg, mdsel_next;
    logic [5:0]         joy_meta_reg, joy_sync_reg;
    logic [11:0]        scr_reg, scr_next;
    logic               md_det_reg, md_det_next;
    logic               six_det_reg, six_det_next;
    logic               step_last, idle_last;
    logic               commit, enter_settle;
    logic [5:0]         pin_act;
    logic [1:0]         pad_type;
    logic [15:0]        commit_word;
    logic [31:0]        joy_all;
    logic [3:0]         type_all;
    logic [1:0]         stb_all;

    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            joy_meta_reg <= 6'h3F;
            joy_sync_reg <= 6'h3F;
        end else begin
            joy_meta_reg <= I_JOY_IN;
            joy_sync_reg <= joy_meta_reg;
        end
    end

    assign pin_act   = ~joy_sync_reg;
    assign step_last = (cnt_reg == CNT_W'(STEP_CYC - 1));
    assign idle_last = (cnt_reg == CNT_W'(IDLE_CYC - 1));

    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state_reg   <= ST_SETTLE;
            phase_reg   <= 3'd0;
            port_reg    <= 1'b0;
            cnt_reg     <= '0;
            mdsel_reg   <= 1'b1;
            scr_reg     <= '0;
            md_det_reg  <= 1'b0;
            six_det_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            port_reg    <= port_next;
            cnt_reg     <= cnt_next;
            mdsel_reg   <= mdsel_next;
            scr_reg     <= scr_next;
            md_det_reg  <= md_det_next;
            six_det_reg <= six_det_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        port_next    = port_reg;
        cnt_next     = cnt_reg + CNT_W'(1);
        commit       = 1'b0;
        enter_settle = 1'b0;
        case (state_reg)
            ST_SETTLE: begin
                if (step_last) begin
                    cnt_next   = '0;
                    state_next = ST_SCAN;
                    phase_next = 3'd0;
                end
            end
            ST_SCAN: begin
                if (step_last) begin
                    cnt_next = '0;
                    if (phase_reg == 3'd7) begin
                        commit = 1'b1;
                        if (!port_reg) begin
                            state_next   = ST_SETTLE;
                            port_next    = 1'b1;
                            enter_settle = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        phase_next = phase_reg + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (idle_last) begin
                    cnt_next     = '0;
                    state_next   = ST_SETTLE;
                    port_next    = 1'b0;
                    enter_settle = 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_SETTLE;
            end
        endcase
        // Select is registered alongside the state so it changes exactly on phase entry.
        mdsel_next = (state_next == ST_SCAN) ? ~phase_next[0] : 1'b1;
    end

    always_comb begin
        scr_next     = scr_reg;
        md_det_next  = md_det_reg;
        six_det_next = six_det_reg;
        if (enter_settle) begin
            scr_next     = '0;
            md_det_next  = 1'b0;
            six_det_next = 1'b0;
        end else if (state_reg == ST_SCAN && step_last) begin
            case (phase_reg)
                3'd0: scr_next[5:0]  = {pin_act[5], pin_act[4], pin_act[0],
                                        pin_act[1], pin_act[2], pin_act[3]};
                3'd1: begin
                    md_det_next    = pin_act[2] & pin_act[3];
                    scr_next[7:6]  = {pin_act[5], pin_act[4]};
                end
                3'd5: six_det_next   = &pin_act[3:0];
                3'd6: scr_next[11:8] = {pin_act[0], pin_act[1], pin_act[2], pin_act[3]};
                default: ;
            endcase
        end
    end

    always_comb begin
        pad_type    = 2'd0;
        commit_word = 16'h0000;
        if (six_det_reg && md_det_reg) begin
            pad_type = 2'd2;
        end else if (md_det_reg) begin
            pad_type = 2'd1;
        end
        case (pad_type)
            2'd2:    commit_word[11:0] = scr_reg;
            2'd1:    commit_word[7:0]  = scr_reg[7:0];
            default: commit_word[5:0]  = scr_reg[5:0];
        endcase
    end

    // One output bank per port; only the bank matching the scanned port loads.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic        hit;
            logic [15:0] joy_reg;
            logic [1:0]  type_reg;
            logic        stb_reg;

            assign hit = commit && (port_reg == 1'(gi));

            always_ff @(posedge I_CLK or negedge I_RESETn) begin
                if (!I_RESETn) begin
                    joy_reg  <= 16'h0000;
                    type_reg <= 2'd0;
                    stb_reg  <= 1'b0;
                end else begin
                    stb_reg <= hit;
                    if (hit) begin
                        joy_reg  <= commit_word;
                        type_reg <= pad_type;
                    end
                end
            end

            assign joy_all[gi*16 +: 16] = joy_reg;
            assign type_all[gi*2 +: 2]  = type_reg;
            assign stb_all[gi]          = stb_reg;
        end
    endgenerate

    assign O_SPLIT = port_reg;
    assign O_MDSEL = mdsel_reg;
    assign O_JOY1  = joy_all[15:0];
    assign O_JOY2  = joy_all[31:16];
    assign O_TYPE1 = type_all[1:0];
    assign O_TYPE2 = type_all[3:2];
    assign O_STB1  = stb_all[0];
    assign O_STB2  = stb_all[1];

endmodule

// File: tb/tb_db9_md_pad_scan.sv
// Bench for db9_md_pad_scan: behavioural pad models on both ports, a commit
// scoreboard per port, and checks on strobe timing and select waveforms.
module tb_db9_md_pad_scan;
    localparam int STEP  = 4;
    localparam int IDLE  = 32;
    localparam int FRAME = 18 * STEP + IDLE;

    typedef struct packed {
        logic [15:0] joy;
        logic [1:0]  typ;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  joy_in;
    logic        split, mdsel;
    logic [15:0] joy1, joy2;
    logic [1:0]  type1, type2;
    logic        stb1, stb2;

    int          pad_kind [2];
    logic [11:0] pad_btn  [2];
    int          fall_cnt = 0;

    exp_t        exp1_q[$];
    exp_t        exp2_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          stb1_n = 0;
    int          stb2_n = 0;
    int          last_stb1_cyc = -1;
    int          last_stb2_cyc = -1;
    logic [15:0] committed1 = 16'h0;
    logic [15:0] committed2 = 16'h0;

    db9_md_pad_scan #(
        .STEP_CYC (STEP),
        .IDLE_CYC (IDLE)
    ) dut (
        .I_CLK    (clk),
        .I_RESETn (rst_n),
        .I_JOY_IN (joy_in),
        .O_SPLIT  (split),
        .O_MDSEL  (mdsel),
        .O_JOY1   (joy1),
        .O_JOY2   (joy2),
        .O_TYPE1  (type1),
        .O_TYPE2  (type2),
        .O_STB1   (stb1),
        .O_STB2   (stb2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pad pins (active low). kind: 0 Atari, 1 MD 3-button, 2 MD 6-button.
    // h counts select falling edges since the port was selected.
    function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                            input logic sel, input int h);
        logic [5:0] p;
        p = {b[5], b[4], b[0], b[1], b[2], b[3]};
        if (kind != 0) begin
            if (sel) begin
                if (h == 3) p[3:0] = (kind == 2) ? {b[8], b[9], b[10], b[11]} : 4'hF;
            end else begin
                if (kind == 2 && h == 3)      p[3:0] = 4'hF;
                else if (kind == 2 && h == 4) p[3:0] = 4'h0;
                else                          p[3:0] = {2'b11, b[2], b[3]};
                p[5:4] = {b[7], b[6]};
            end
        end
        return ~p;
    endfunction

    always_comb joy_in = pad_pins(pad_kind[split], pad_btn[split], mdsel, fall_cnt);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_split"}, split, 0);
        check_eq({tag, "_mdsel"}, mdsel, 1);
        check_eq({tag, "_joy1"},  joy1,  0);
        check_eq({tag, "_joy2"},  joy2,  0);
        check_eq({tag, "_type1"}, type1, 0);
        check_eq({tag, "_type2"}, type2, 0);
        check_eq({tag, "_stb1"},  stb1,  0);
        check_eq({tag, "_stb2"},  stb2,  0);
    endtask

    task automatic wait_stb(input string tag, input int port, input int target);
        int n = 0;
        while (((port == 1) ? stb1_n : stb2_n) < target && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, (port == 1) ? stb1_n : stb2_n, target);
    endtask

    task automatic wait_cyc_mod(input string tag, input int target);
        int n = 0;
        while ((cyc % FRAME) != target && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, cyc % FRAME, target);
    endtask

    // Monitor: pad select-edge counter, waveform tallies and scoreboard pops.
    initial begin : monitor
        logic mdsel_m, split_m, stb1_m, stb2_m, mdfall;
        int   lows, falls, tog;
        bit   first;
        exp_t e;
        mdsel_m = 1'b1; split_m = 1'b0; stb1_m = 1'b0; stb2_m = 1'b0;
        lows = 0; falls = 0; tog = 0; first = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fall_cnt = 0; lows = 0; falls = 0; tog = 0; first = 1'b1;
                mdsel_m = 1'b1; split_m = 1'b0; stb1_m = 1'b0; stb2_m = 1'b0;
                committed1 = 16'h0; committed2 = 16'h0;
            end else begin
                mdfall = mdsel_m && !mdsel;
                if (split != split_m) begin
                    fall_cnt = 0;
                    tog++;
                end else if (mdfall) begin
                    fall_cnt++;
                end
                if (!mdsel) lows++;
                if (mdfall) falls++;
                if (stb1) begin
                    stb1_n++;
                    last_stb1_cyc = cyc;
                    $display("commit port1 cyc=%0d joy=0x%04h type=%0d", cyc, joy1, type1);
                    if (exp1_q.size() == 0) begin
                        check_eq("port1_unexpected_commit", 1, 0);
                    end else begin
                        e = exp1_q.pop_front();
                        check_eq("joy1", joy1, e.joy);
                        check_eq("type1", type1, e.typ);
                        committed1 = e.joy;
                    end
                    check_eq("joy2_hold_at_stb1", joy2, committed2);
                    check_eq("stb2_with_stb1", stb2, 0);
                    check_eq("stb1_width", stb1_m, 0);
                    check_eq("mdsel_low_cycles_p1", lows, 4 * STEP);
                    check_eq("mdsel_pulses_p1", falls, 4);
                    check_eq("split_toggles_p1", tog, first ? 1 : 2);
                    check_eq("split_after_p1", split, 1);
                    lows = 0; falls = 0; tog = 0; first = 1'b0;
                end
                if (stb2) begin
                    stb2_n++;
                    last_stb2_cyc = cyc;
                    $display("commit port2 cyc=%0d joy=0x%04h type=%0d", cyc, joy2, type2);
                    if (exp2_q.size() == 0) begin
                        check_eq("port2_unexpected_commit", 1, 0);
                    end else begin
                        e = exp2_q.pop_front();
                        check_eq("joy2", joy2, e.joy);
                        check_eq("type2", type2, e.typ);
                        committed2 = e.joy;
                    end
                    check_eq("joy1_hold_at_stb2", joy1, committed1);
                    check_eq("stb1_with_stb2", stb1, 0);
                    check_eq("stb2_width", stb2_m, 0);
                    check_eq("mdsel_low_cycles_p2", lows, 4 * STEP);
                    check_eq("mdsel_pulses_p2", falls, 4);
                    check_eq("split_toggles_p2", tog, 0);
                    check_eq("split_during_p2", split, 1);
                    lows = 0; falls = 0; tog = 0;
                end
                mdsel_m = mdsel; split_m = split; stb1_m = stb1; stb2_m = stb2;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Port 1: 6-button, Z + Start. Port 2: 3-button, A + Right.
        pad_kind[0] = 2; pad_btn[0] = 12'h880;
        pad_kind[1] = 1; pad_btn[1] = 12'h041;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        exp1_q.push_back('{joy: 16'h0880, typ: 2'd2});
        exp1_q.push_back('{joy: 16'h0880, typ: 2'd2});
        exp2_q.push_back('{joy: 16'h0041, typ: 2'd1});
        rst_n = 1'b1;

        wait_stb("stb1_count_a", 1, 1);
        check_eq("stb1_first_cycle", last_stb1_cyc, 9 * STEP);
        wait_stb("stb2_count_a", 2, 1);
        check_eq("stb2_first_cycle", last_stb2_cyc, 18 * STEP);
        wait_stb("stb1_count_b", 1, 2);
        check_eq("stb1_second_cycle", last_stb1_cyc, 9 * STEP + FRAME);

        // Port 1 becomes an Atari pad: Up + pin6.
        pad_kind[0] = 0; pad_btn[0] = 12'h018;
        exp1_q.push_back('{joy: 16'h0018, typ: 2'd0});
        exp2_q.push_back('{joy: 16'h0041, typ: 2'd1});
        wait_stb("stb2_count_b", 2, 2);
        check_eq("stb2_second_cycle", last_stb2_cyc, 18 * STEP + FRAME);
        wait_stb("stb1_count_c", 1, 3);
        check_eq("stb1_third_cycle", last_stb1_cyc, 9 * STEP + 2 * FRAME);

        // 6-button with B held; B released during phase 4 of the next port 1 scan.
        pad_kind[0] = 2; pad_btn[0] = 12'h010;
        exp1_q.push_back('{joy: 16'h0010, typ: 2'd2});
        exp1_q.push_back('{joy: 16'h0000, typ: 2'd2});
        repeat (3) exp2_q.push_back('{joy: 16'h0041, typ: 2'd1});
        wait_cyc_mod("align_phase4", 5 * STEP + 1);
        pad_btn[0] = 12'h000;
        wait_stb("stb1_count_d", 1, 4);
        check_eq("stb1_fourth_cycle", last_stb1_cyc, 9 * STEP + 3 * FRAME);
        wait_stb("stb1_count_e", 1, 5);
        check_eq("stb1_fifth_cycle", last_stb1_cyc, 9 * STEP + 4 * FRAME);

        // Reset in the middle of port 1 phase 3 (select low).
        wait_cyc_mod("align_phase3", 4 * STEP + 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midscan");
        exp1_q.delete();
        exp2_q.delete();
        pad_kind[0] = 0; pad_btn[0] = 12'h021;
        exp1_q.push_back('{joy: 16'h0021, typ: 2'd0});
        exp2_q.push_back('{joy: 16'h0041, typ: 2'd1});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_stb("stb1_count_f", 1, 6);
        check_eq("stb1_after_reset_cycle", last_stb1_cyc, 9 * STEP);
        wait_stb("stb2_count_f", 2, 6);
        check_eq("stb2_after_reset_cycle", last_stb2_cyc, 18 * STEP);

        check_eq("exp1_left", exp1_q.size(), 0);
        check_eq("exp2_left", exp2_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
